// File: rtl/cmp_window_stats.sv
// cmp_window_stats
//   Collects results from an 8-bit magnitude comparator over a window of WIN
//   accepted samples. When the window is complete, it presents a summary on a
//   valid/ready output. While that summary waits, the input side is stalled.
//
// Ports
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready           sample handshake
//   in_lt, in_gt, in_eq           comparator flags for the sample
//   in_a                          operand A that produced the flags
//   out_valid / out_ready         summary handshake
//   out_lt_cnt, out_gt_cnt,       per-class sample counts in the window
//   out_eq_cnt, out_err_cnt       (err = flags not exactly one-hot)
//   out_max_a                     unsigned maximum of in_a over the window

module cmp_window_stats #(
  parameter int DW  = 8,
  parameter int WIN = 16,
  parameter int CW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_lt,
  input  logic          in_gt,
  input  logic          in_eq,
  input  logic [DW-1:0] in_a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_lt_cnt,
  output logic [CW-1:0] out_gt_cnt,
  output logic [CW-1:0] out_eq_cnt,
  output logic [CW-1:0] out_err_cnt,
  output logic [DW-1:0] out_max_a
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIN - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] idx;
  logic [CW-1:0] lt_cnt;
  logic [CW-1:0] gt_cnt;
  logic [CW-1:0] eq_cnt;
  logic [CW-1:0] err_cnt;
  logic [DW-1:0] max_a;
  logic          accept;
  logic          release_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (idx == LAST_IDX)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign release_sum = out_valid && out_ready;

  // In HOLD the accumulators are not written, so they can drive the summary
  // outputs directly and stay stable for any stall length. The first sample of
  // a window loads max_a unconditionally. A value left over from an earlier
  // window can therefore never win the comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      lt_cnt  <= '0;
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      err_cnt <= '0;
      max_a   <= '0;
    end else if (release_sum) begin
      idx     <= '0;
      lt_cnt  <= '0;
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      err_cnt <= '0;
      max_a   <= '0;
    end else if (accept) begin
      idx <= idx + ONE;
      case ({in_lt, in_gt, in_eq})
        3'b100:  lt_cnt  <= lt_cnt + ONE;
        3'b010:  gt_cnt  <= gt_cnt + ONE;
        3'b001:  eq_cnt  <= eq_cnt + ONE;
        default: err_cnt <= err_cnt + ONE;
      endcase
      if ((idx == '0) || (in_a > max_a)) begin
        max_a <= in_a;
      end
    end
  end

  assign out_lt_cnt  = lt_cnt;
  assign out_gt_cnt  = gt_cnt;
  assign out_eq_cnt  = eq_cnt;
  assign out_err_cnt = err_cnt;
  assign out_max_a   = max_a;

endmodule

// File: tb/tb_cmp_window_stats.sv
// tb_cmp_window_stats
//   Directed bench for cmp_window_stats. A WIN=4 instance runs the table of
//   windows and the hand-written corner sequences. A WIN=1 instance checks
//   the alternating ACCUM/HOLD behaviour.

module tb_cmp_window_stats;

  localparam logic [2:0] F_LT = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_EQ = 3'b001;

  typedef struct packed {
    logic [11:0] flags;
    logic [31:0] a;
    logic [7:0]  lt;
    logic [7:0]  gt;
    logic [7:0]  eq;
    logic [7:0]  err;
    logic [7:0]  max_a;
  } window_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_lt = 1'b0;
  logic       in_gt = 1'b0;
  logic       in_eq = 1'b0;
  logic [7:0] in_a = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_lt_cnt;
  logic [2:0] out_gt_cnt;
  logic [2:0] out_eq_cnt;
  logic [2:0] out_err_cnt;
  logic [7:0] out_max_a;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [7:0] in_a1 = '0;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;
  logic       out_lt_cnt1;
  logic       out_gt_cnt1;
  logic       out_eq_cnt1;
  logic       out_err_cnt1;
  logic [7:0] out_max_a1;

  int assert_count = 0;
  int fail_count   = 0;

  window_t vectors [5];

  always #5 clk = ~clk;

  cmp_window_stats #(.DW(8), .WIN(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_lt       (in_lt),
    .in_gt       (in_gt),
    .in_eq       (in_eq),
    .in_a        (in_a),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_lt_cnt  (out_lt_cnt),
    .out_gt_cnt  (out_gt_cnt),
    .out_eq_cnt  (out_eq_cnt),
    .out_err_cnt (out_err_cnt),
    .out_max_a   (out_max_a)
  );

  cmp_window_stats #(.DW(8), .WIN(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid1),
    .in_ready    (in_ready1),
    .in_lt       (1'b0),
    .in_gt       (1'b1),
    .in_eq       (1'b0),
    .in_a        (in_a1),
    .out_valid   (out_valid1),
    .out_ready   (out_ready1),
    .out_lt_cnt  (out_lt_cnt1),
    .out_gt_cnt  (out_gt_cnt1),
    .out_eq_cnt  (out_eq_cnt1),
    .out_err_cnt (out_err_cnt1),
    .out_max_a   (out_max_a1)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkSummary(input string tag, input window_t w);
    checkOutput({tag, ".out_valid"}, out_valid, 1);
    checkOutput({tag, ".in_ready"}, in_ready, 0);
    checkOutput({tag, ".lt"}, out_lt_cnt, w.lt);
    checkOutput({tag, ".gt"}, out_gt_cnt, w.gt);
    checkOutput({tag, ".eq"}, out_eq_cnt, w.eq);
    checkOutput({tag, ".err"}, out_err_cnt, w.err);
    checkOutput({tag, ".max_a"}, out_max_a, w.max_a);
  endtask

  // Sends the four samples of a window back-to-back, starting on a negedge.
  // It then checks the summary one clock after the last accept.
  task automatic applyStimulus(input string tag, input window_t w);
    for (int s = 0; s < 4; s++) begin
      in_valid = 1'b1;
      {in_lt, in_gt, in_eq} = w.flags[11 - 3*s -: 3];
      in_a = w.a[31 - 8*s -: 8];
      @(negedge clk);
      if (s < 3) checkOutput({tag, ".early_valid"}, out_valid, 0);
    end
    in_valid = 1'b0;
    checkSummary(tag, w);
  endtask

  // Stalls for hold_cycles while offering an input sample that must be ignored.
  // It then takes the summary and checks that the block is back in ACCUM and cleared.
  task automatic releaseSummary(input string tag, input window_t w, input int hold_cycles);
    for (int c = 0; c < hold_cycles; c++) begin
      in_valid = 1'b1;
      {in_lt, in_gt, in_eq} = F_GT;
      in_a = 8'd254;
      @(negedge clk);
      checkSummary({tag, ".stall"}, w);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, ".post_valid"}, out_valid, 0);
    checkOutput({tag, ".post_ready"}, in_ready, 1);
    checkOutput({tag, ".post_gt"}, out_gt_cnt, 0);
    checkOutput({tag, ".post_max"}, out_max_a, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    window_t gap_w;
    logic [6:0] gap_pattern;
    logic [7:0] gap_a [4];
    int         gap_n;
    int         prev_a;

    vectors[0] = '{flags: {F_LT, F_GT, F_EQ, F_EQ},
                   a: {8'd50, 8'd80, 8'd100, 8'd7},
                   lt: 8'd1, gt: 8'd1, eq: 8'd2, err: 8'd0, max_a: 8'd100};
    vectors[1] = '{flags: {3'b000, 3'b110, 3'b111, F_EQ},
                   a: {8'd10, 8'd20, 8'd30, 8'd5},
                   lt: 8'd0, gt: 8'd0, eq: 8'd1, err: 8'd3, max_a: 8'd30};
    vectors[2] = '{flags: {F_GT, F_GT, F_GT, F_GT},
                   a: {8'd200, 8'd200, 8'd200, 8'd200},
                   lt: 8'd0, gt: 8'd4, eq: 8'd0, err: 8'd0, max_a: 8'd200};
    vectors[3] = '{flags: {F_LT, F_LT, F_GT, 3'b011},
                   a: {8'd255, 8'd0, 8'd1, 8'd2},
                   lt: 8'd2, gt: 8'd1, eq: 8'd0, err: 8'd1, max_a: 8'd255};
    vectors[4] = '{flags: {F_EQ, F_EQ, F_EQ, F_EQ},
                   a: {8'd3, 8'd2, 8'd1, 8'd0},
                   lt: 8'd0, gt: 8'd0, eq: 8'd4, err: 8'd0, max_a: 8'd3};

    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst.out_valid", out_valid, 0);
    checkOutput("rst.max_a", out_max_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst.in_ready", in_ready, 1);
    checkOutput("rst.lt", out_lt_cnt, 0);
    checkOutput("rst.err", out_err_cnt, 0);

    // The table windows. The first one is stalled for 5 cycles before it is taken.
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("vec%0d", i), vectors[i]);
      releaseSummary($sformatf("vec%0d", i), vectors[i], (i == 0) ? 5 : 0);
    end

    // Assert reset while a summary is pending. The summary must disappear immediately.
    applyStimulus("rst_hold", vectors[1]);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_hold.out_valid", out_valid, 0);
    checkOutput("rst_hold.err", out_err_cnt, 0);
    checkOutput("rst_hold.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Assert reset after 2 of 4 samples, then run a fresh all-GT window.
    for (int s = 0; s < 2; s++) begin
      in_valid = 1'b1;
      {in_lt, in_gt, in_eq} = F_LT;
      in_a = 8'd250;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("rst_mid.lt_before", out_lt_cnt, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid.lt", out_lt_cnt, 0);
    checkOutput("rst_mid.max_a", out_max_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("rst_mid.fresh", vectors[2]);
    releaseSummary("rst_mid.fresh", vectors[2], 0);

    // Gapped input stream. out_ready stays high throughout ACCUM, and that must have no effect.
    gap_pattern = 7'b1001011;
    gap_a[0] = 8'd9; gap_a[1] = 8'd4; gap_a[2] = 8'd12; gap_a[3] = 8'd1;
    gap_w = '{flags: '0, a: '0, lt: 8'd0, gt: 8'd0, eq: 8'd4, err: 8'd0, max_a: 8'd12};
    gap_n = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = gap_pattern[6 - c];
      {in_lt, in_gt, in_eq} = F_EQ;
      in_a = in_valid ? gap_a[gap_n] : 8'd255;
      if (in_valid) gap_n++;
      @(negedge clk);
      if (c < 6) checkOutput("gap.early_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    checkSummary("gap", gap_w);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("gap.post_valid", out_valid, 0);
    checkOutput("gap.post_ready", in_ready, 1);

    // WIN=1 with continuous traffic. The block alternates ACCUM and HOLD.
    out_ready1 = 1'b1;
    prev_a = 0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("win1.in_ready", in_ready1, (i % 2 == 0) ? 1 : 0);
      checkOutput("win1.out_valid", out_valid1, (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 1) begin
        checkOutput("win1.gt", out_gt_cnt1, 1);
        checkOutput("win1.max_a", out_max_a1, prev_a);
      end
      in_valid1 = 1'b1;
      in_a1 = 8'(i * 10 + 5);
      if (i % 2 == 0) prev_a = i * 10 + 5;
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
